// File: rtl/reg_arb_pkg.sv
// Shared types and default widths for the register-bank access arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam int         DEF_ADDR_W  = 2;
    localparam int         DEF_DATA_W  = 16;
    // Address 0 is the status/sum register and cannot be written by requesters.
    localparam logic [3:0] DEF_RO_MASK = 4'b0001;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating priority encoder: first set request at or after ptr_i,
// wrapping modulo N (N need not be a power of two).
module rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    localparam logic [IDX_W:0] NUM = (IDX_W+1)'(N);

    always_comb begin
        logic [IDX_W:0]   pos;
        logic [IDX_W-1:0] cand;
        logic             found;
        gnt_o = '0;
        idx_o = '0;
        pos   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (pos >= NUM) pos = pos - NUM;
            cand = pos[IDX_W-1:0];
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto a single-port register bank.
// Optional macro REG_ARB_SPI_PRIORITY_EN gives requester 0 (SPI) absolute priority.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int                        NUM_REQ = 3,
    parameter int                        ADDR_W  = DEF_ADDR_W,
    parameter int                        DATA_W  = DEF_DATA_W,
    parameter logic [(1<<ADDR_W)-1:0]    RO_MASK = DEF_RO_MASK
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic                         rsp_err,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         bank_we,
    output logic                         bank_re,
    output logic [ADDR_W-1:0]            bank_addr,
    output logic [DATA_W-1:0]            bank_wdata,
    input  logic [DATA_W-1:0]            bank_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_q;
    logic               we_q;
    logic               err_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    logic [NUM_REQ-1:0] pick_req, pick_gnt, win_oh;
    logic [IDX_W-1:0]   pick_idx, win_idx;
    logic               pick_any, spi_win, any_req;

`ifdef REG_ARB_SPI_PRIORITY_EN
    assign spi_win  = req_valid[0];
    assign pick_req = {req_valid[NUM_REQ-1:1], 1'b0};
`else
    assign spi_win  = 1'b0;
    assign pick_req = req_valid;
`endif

    rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req_i (pick_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign win_oh  = spi_win ? NUM_REQ'(1) : pick_gnt;
    assign win_idx = spi_win ? '0 : pick_idx;
    assign any_req = spi_win | pick_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE:   if (any_req) state_d = ISSUE;
            ISSUE:  state_d = we_q ? RESP : RDWAIT;
            RDWAIT: state_d = RESP;
            RESP: begin
                state_d  = IDLE;
                rr_ptr_d = (gnt_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_q + IDX_W'(1);
`ifdef REG_ARB_SPI_PRIORITY_EN
                // SPI grants bypass the rotation, so they must not disturb it.
                if (gnt_q == '0) rr_ptr_d = rr_ptr_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_err    = 1'b0;
        bank_we    = 1'b0;
        bank_re    = 1'b0;
        bank_addr  = '0;
        bank_wdata = '0;
        if (state_q == IDLE) begin
            req_ready = win_oh;
        end else begin
            bank_addr  = addr_q;
            bank_wdata = wdata_q;
        end
        if (state_q == ISSUE) begin
            bank_re = ~we_q;
            bank_we = we_q & ~RO_MASK[addr_q];
        end
        if (state_q == RESP) begin
            rsp_valid[gnt_q] = 1'b1;
            rsp_err          = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (any_req) begin
                    gnt_q   <= win_idx;
                    we_q    <= req_we[win_idx];
                    addr_q  <= addr_arr[win_idx];
                    wdata_q <= wdata_arr[win_idx];
                    err_q   <= 1'b0;
                end
                ISSUE:   err_q   <= we_q & RO_MASK[addr_q];
                RDWAIT:  rdata_q <= bank_rdata;
                default: ;
            endcase
        end
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: directed vector table, rotation/reset sequences,
// and a randomized run against a transaction-level reference model.
module tb_reg_access_arbiter;

    localparam int N  = 3;
    localparam int AW = 2;
    localparam int DW = 16;
    localparam logic [3:0] RO = 4'b0001;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            rsp_err, bank_we, bank_re;
    logic [DW-1:0]   rsp_rdata, bank_wdata, bank_rdata;
    logic [AW-1:0]   bank_addr;
    logic [DW-1:0]   mem [4];

    int n_chk = 0;
    int n_pass = 0;

    reg_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .bank_we(bank_we), .bank_re(bank_re), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
    );

    always #5 clk = ~clk;

    // Register bank: one-cycle read latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            bank_rdata <= '0;
        end else begin
            if (bank_re) bank_rdata <= mem[bank_addr];
            if (bank_we) mem[bank_addr] <= bank_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[r]         = v;
        req_we[r]            = we;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic reset_dut();
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        int            r;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          bwe;
        logic          err;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl[9];

    task automatic run_vec(input vec_t v);
        tick();
        set_req(v.r, 1'b1, v.we, v.a, v.d);
        #1 chk("ready", 32'(req_ready), 32'(oh(v.r)));
        tick();
        req_valid[v.r] = 1'b0;
        #1 chk("bank_we", 32'(bank_we), 32'(v.bwe));
        chk("bank_re", 32'(bank_re), 32'(!v.we));
        chk("bank_addr", 32'(bank_addr), 32'(v.a));
        if (v.we) chk("bank_wdata", 32'(bank_wdata), 32'(v.d));
        chk("rsp_early", 32'(rsp_valid), 0);
        if (!v.we) begin
            tick();
            #1 chk("rsp_rdwait", 32'(rsp_valid), 0);
        end
        tick();
        #1 chk("rsp_valid", 32'(rsp_valid), 32'(oh(v.r)));
        chk("rsp_err", 32'(rsp_err), 32'(v.err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(v.rd));
        tick();
        #1 chk("rsp_idle", 32'(rsp_valid), 0);
        chk("err_idle", 32'(rsp_err), 0);
        chk("addr_idle", 32'(bank_addr), 0);
    endtask

    // Reference model state for the randomized phase.
    logic [DW-1:0] rmem [4];
    int            mptr;

    function automatic int model_winner(input logic [N-1:0] v);
`ifdef REG_ARB_SPI_PRIORITY_EN
        if (v[0]) return 0;
        for (int k = 0; k < N; k++) if (v[(mptr + k) % N] && ((mptr + k) % N) != 0) return (mptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (v[(mptr + k) % N]) return (mptr + k) % N;
`endif
        return -1;
    endfunction

    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        tbl[0] = '{1, 1'b1, 2'd2, 16'h1234, 1'b1, 1'b0, 16'h0000};
        tbl[1] = '{2, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 16'h1234};
        tbl[2] = '{0, 1'b1, 2'd0, 16'hFFFF, 1'b0, 1'b1, 16'h1234};
        tbl[3] = '{0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        tbl[4] = '{1, 1'b1, 2'd3, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
        tbl[5] = '{0, 1'b0, 2'd3, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
        tbl[6] = '{2, 1'b1, 2'd1, 16'h0A5A, 1'b1, 1'b0, 16'hBEEF};
        tbl[7] = '{1, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 16'h0A5A};
        tbl[8] = '{2, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000};

        // Reset state
        #2;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        chk("rst_bank", {bank_we, bank_re, 14'(bank_addr), bank_wdata}, 0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(tbl[i]);

`ifndef REG_ARB_SPI_PRIORITY_EN
        // All requesters hold valid reads: strict rotation, 4 cycles apart.
        begin
            int acc_i[$];
            int acc_c[$];
            reset_dut();
            for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
            for (int c = 0; c < 60 && acc_i.size() < 6; c++) begin
                #1;
                if (req_ready != 0) begin
                    chk("rot_onehot", 32'($onehot(req_ready)), 1);
                    acc_i.push_back(oh2i(req_ready));
                    acc_c.push_back(c);
                end
                tick();
            end
            chk("rot_count", acc_i.size(), 6);
            for (int k = 0; k < acc_i.size(); k++) begin
                chk("rot_order", acc_i[k], k % N);
                if (k > 0) chk("rot_spacing", acc_c[k] - acc_c[k-1], 4);
            end
            req_valid = '0;
            repeat (5) tick();
        end
`else
        // SPI priority: req0 keeps re-requesting and wins until it idles.
        begin
            int acc_i[$];
            int cnt0 = 0;
            logic [N-1:0] drop = '0;
            logic raise0 = 1'b0;
            reset_dut();
            for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
            for (int c = 0; c < 80 && acc_i.size() < 5; c++) begin
                tick();
                req_valid = req_valid & ~drop;
                drop = '0;
                if (raise0) req_valid[0] = 1'b1;
                raise0 = 1'b0;
                #1;
                if (req_ready != 0) begin
                    acc_i.push_back(oh2i(req_ready));
                    drop = req_ready;
                    if (req_ready[0]) cnt0++;
                end
                if (rsp_valid[0] && cnt0 < 3) raise0 = 1'b1;
            end
            chk("prio_count", acc_i.size(), 5);
            for (int k = 0; k < acc_i.size(); k++)
                chk("prio_order", acc_i[k], (k < 3) ? 0 : k - 2);
            req_valid = '0;
            repeat (5) tick();
        end
`endif

        // Reset during RDWAIT aborts the read; rotation restarts at requester 0.
        reset_dut();
        run_vec('{1, 1'b1, 2'd1, 16'h5555, 1'b1, 1'b0, 16'h0000});
        tick();
        set_req(1, 1'b1, 1'b0, 2'd1, '0);
        #1 chk("abort_ready", 32'(req_ready), 32'(oh(1)));
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        #1 chk("abort_rsp", 32'(rsp_valid), 0);
        chk("abort_bank", {bank_we, bank_re, 14'(bank_addr), bank_wdata}, 0);
        chk("abort_rdata", 32'(rsp_rdata), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1 chk("abort_quiet", 32'(rsp_valid), 0);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
        #1 chk("restart_ready", 32'(req_ready), 32'(oh(0)));
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Randomized traffic against the transaction-level model.
        begin
            logic [N-1:0] busy = '0;
            logic [N-1:0] exp_rv, exp_rdy;
            logic         infl = 1'b0;
            int           free_at = 0, due = 0, gi = 0;
            logic         g_we = 1'b0, exp_err = 1'b0;
            logic [DW-1:0] exp_rd = '0, last_rd = '0;
            reset_dut();
            mptr = 0;
            for (int i = 0; i < 4; i++) rmem[i] = '0;
            for (int c = 0; c < 1500; c++) begin
                tick();
                for (int i = 0; i < N; i++) begin
                    if (busy[i] && req_valid[i]) req_valid[i] = 1'b0;
                    else if (!busy[i] && !req_valid[i] && $urandom_range(0, 2) == 0)
                        set_req(i, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
                end
                #1;
                exp_rv = '0;
                if (infl && c == due) begin
                    exp_rv[gi] = 1'b1;
                    if (!g_we) last_rd = exp_rd;
`ifdef REG_ARB_SPI_PRIORITY_EN
                    if (gi != 0) mptr = (gi + 1) % N;
`else
                    mptr = (gi + 1) % N;
`endif
                    infl = 1'b0;
                    free_at = c + 1;
                end
                chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
                chk("rnd_rsp_err", 32'(rsp_err), (exp_rv != 0) ? 32'(exp_err) : 0);
                chk("rnd_rdata", 32'(rsp_rdata), 32'(last_rd));
                busy = busy & ~rsp_valid;
                exp_rdy = '0;
                if (!infl && c >= free_at && req_valid != 0) begin
                    logic [AW-1:0] a;
                    gi = model_winner(req_valid);
                    exp_rdy[gi] = 1'b1;
                    g_we = req_we[gi];
                    a = req_addr[gi*AW +: AW];
                    exp_err = g_we && RO[a];
                    if (!g_we) exp_rd = rmem[a];
                    else if (!RO[a]) rmem[a] = req_wdata[gi*DW +: DW];
                    due = c + (g_we ? 2 : 3);
                    infl = 1'b1;
                end
                chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
                busy = busy | (req_ready & req_valid);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares the single-port 16-bit control register bank between NUM_REQ requesters: the SPI command/data interface plus internal engines.
- Requester 0 is the SPI slave interface.
- Serialises all accesses into one-at-a-time bank reads and writes using a round-robin grant.
- Returns per-requester responses, and rejects writes to read-only addresses (e.g. status/sum register 0).

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- ADDR_W, 2: register address width (bank depth 2**ADDR_W).
- DATA_W, 16: register data width.
- RO_MASK, 4'b0001: bit a set means address a is read-only (width 2**ADDR_W).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  NUM_REQ  one-hot completion strobe.
- rsp_err  out  1  qualifies rsp_valid: write to read-only address.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads.
- bank_we  out  1  bank write strobe.
- bank_re  out  1  bank read strobe.
- bank_addr  out  ADDR_W  bank address.
- bank_wdata  out  DATA_W  bank write data.
- bank_rdata  in  DATA_W  bank read data, valid one cycle after bank_re.

Behaviour:
- Reset: state IDLE, rr_ptr=0. All outputs 0, including latched addr/wdata/rdata/grant.
- Reset asserted mid-transaction aborts it. No rsp_valid is produced; the requester re-requests.
- States and transitions:
  - IDLE: if any req_valid, the winner is the first set req_valid at index >= rr_ptr, wrapping modulo NUM_REQ.
    - req_ready[winner] is asserted combinationally in this cycle (only in IDLE, only one bit).
    - Handshake = req_valid & req_ready. Latch we/addr/wdata/grant_idx, then go to ISSUE.
    - No req_valid: stay in IDLE.
  - ISSUE:
    - Read: bank_re=1, go to RDWAIT.
    - Write with RO_MASK[addr]=0: bank_we=1, go to RESP.
    - Write with RO_MASK[addr]=1: no strobe, set err flag, go to RESP.
    - bank_addr and bank_wdata hold the latched values from ISSUE through RESP. They are 0 in IDLE.
  - RDWAIT: capture bank_rdata into rsp_rdata, go to RESP.
  - RESP: rsp_valid[grant_idx]=1 for exactly one cycle, rsp_err=err flag.
    - rr_ptr <= (grant_idx+1) mod NUM_REQ (explicit wrap, no power-of-2 assumption).
    - Go to IDLE.
- Latency from accept cycle T:
  - write: bank_we at T+1, rsp_valid at T+2.
  - read: bank_re at T+1, rsp_valid with rdata at T+3.
- Throughput: one write per 3 cycles, one read per 4 cycles.
- Requester protocol:
  - Hold valid and payload stable until ready.
  - Deassert valid after ready; keep it low until rsp_valid, then a new request is allowed.
  - valid dropped before ready has no effect: arbitration re-evaluates every IDLE cycle.
- rsp_rdata holds its last read value between responses. It is not cleared on writes.
- rsp_err is 0 whenever no rsp_valid is asserted.
- All requesters valid simultaneously: grants rotate strictly, e.g. 0,1,2,0… for NUM_REQ=3.

Optional Feature:
- Macro: REG_ARB_SPI_PRIORITY_EN.
- Defined:
  - Requester 0 (SPI) wins whenever req_valid[0] is set in IDLE.
  - Otherwise the round-robin search runs over 1..NUM_REQ-1.
  - rr_ptr is not updated when requester 0 is granted.
- Undefined: pure round-robin over all requesters as above.

Decomposition:
- Package reg_arb_pkg:
  - state enum {IDLE, ISSUE, RDWAIT, RESP};
  - default width constants (ADDR_W=2, DATA_W=16);
  - default RO_MASK.
- One sub-module, rr_picker:
  - combinational rotating priority encoder;
  - inputs: request vector and rr_ptr;
  - outputs: one-hot grant and index, plus any-valid.

Test Plan:
1. Req1 writes 16'h1234 to addr 2 at T → req_ready[1] at T, bank_we/addr=2/wdata=16'h1234 at T+1, rsp_valid[1] at T+2, rsp_err=0.
2. Req2 reads addr 2 with bank_rdata=16'h1234 → bank_re at T+1, rsp_valid[2] at T+3, rsp_rdata=16'h1234.
3. Req0 writes 16'hFFFF to addr 0 (RO_MASK=4'b0001) → no bank_we, rsp_valid[0] at T+2 with rsp_err=1.
4. All three hold valid continuously (reads) → grant order 0,1,2,0,1,2, each accept 4 cycles apart, with no starvation.
5. With REG_ARB_SPI_PRIORITY_EN, req0 re-requests after every response alongside req1/req2 → req0 granted every transaction until it idles, then req1, then req2.
6. Reset asserted during RDWAIT → all outputs 0 immediately, no rsp_valid. After release, a new request is granted starting from rr_ptr=0.
